// File: rtl/mix_columns_iter_if.sv
// Handshake bundle for the iterative MixColumns block: one valid/ready
// channel carrying the input state (plus its bypass flag) and one carrying
// the transformed state back out.
interface mix_columns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_bypass;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  // Upstream/downstream side that feeds states in and drains results.
  modport master (
    output in_valid,
    output in_bypass,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // The MixColumns engine itself.
  modport slave (
    input  in_valid,
    input  in_bypass,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative forward AES MixColumns for the encrypt datapath.
// A 128-bit state is captured in IDLE, COLS_PER_CYCLE columns are rewritten
// in place each BUSY cycle, and the finished state is presented in DONE
// until the consumer takes it. The bypass flag skips straight to DONE so the
// final AES round can reuse the same pipeline slot without mixing.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  mix_columns_iter_if.slave   bus
);

  // Only widths that divide the four columns evenly make sense.
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // col_cnt value of the final column group and its per-cycle advance.
  // For four columns per cycle the step truncates to zero, which is harmless
  // because the first group is also the last one.
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [127:0]   work_q;
  logic [127:0]   work_d;
  logic           bypass_q;
  logic           bypass_d;
  logic [1:0]     col_cnt_q;
  logic [1:0]     col_cnt_d;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of MixColumns; row0 sits in the most significant byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

  // State register; async reset parks the engine in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every other transition, including a
  // pending accept in IDLE and a pending drain in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.in_bypass ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (col_cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  // Handshake outputs come from the state alone, so they never see input
  // glitches; the result is the working register itself.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.out_data  = work_q;
  end

  // Datapath: capture on accept, then rewrite the current column group in
  // place. A flush freezes the working register and counter where they are.
  always_comb begin
    work_d    = work_q;
    bypass_d  = bypass_q;
    col_cnt_d = col_cnt_q;
    if (!flush) begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            work_d    = bus.in_data;
            bypass_d  = bus.in_bypass;
            col_cnt_d = 2'd0;
          end
        end
        BUSY: begin
          for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            if (!bypass_q) begin
              work_d[{col_cnt_q + 2'(k), 5'b00000} +: 32] =
                mix_column(work_q[{col_cnt_q + 2'(k), 5'b00000} +: 32]);
            end
          end
          if (col_cnt_q != LAST_CNT) begin
            col_cnt_d = col_cnt_q + CNT_STEP;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Working register, bypass flag and column counter; all cleared by reset
  // so out_data reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q    <= '0;
      bypass_q  <= 1'b0;
      col_cnt_q <= 2'd0;
    end else begin
      work_q    <= work_d;
      bypass_q  <= bypass_d;
      col_cnt_q <= col_cnt_d;
    end
  end

endmodule
